// File: rtl/rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : rll_key_loader
//  Purpose  : Serial key loader for RLL-locked cores: assembles beats into a
//             shadow register, validates an XOR-fold tag, drives keyIn.
//  Revision : 1.0  initial release
// ============================================================================
module rll_key_loader #(
    parameter int                    KEY_WIDTH = 32,
    parameter int                    CHUNK_W   = 8,
    parameter int                    TAG_W     = 8,
    parameter int                    MAX_FAILS = 3,
    parameter logic [KEY_WIDTH-1:0]  DECOY     = 32'hA5A5A5A5
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  logic [CHUNK_W-1:0]                load_data,
    input  logic                              load_last,
    input  logic [TAG_W-1:0]                  tag_in,
    input  logic                              key_clear,
    output logic [KEY_WIDTH-1:0]              key_out,
    output logic                              key_valid,
    output logic [$clog2(MAX_FAILS+1)-1:0]    fail_cnt,
    output logic                              locked_out
);

    localparam int c_BEATS  = KEY_WIDTH / CHUNK_W;
    localparam int c_SLICES = KEY_WIDTH / TAG_W;
    localparam int c_CNT_W  = (c_BEATS > 1) ? $clog2(c_BEATS) : 1;
    localparam int c_FAIL_W = $clog2(MAX_FAILS + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CHECK  = 2'd2,
        S_LOCKED = 2'd3
    } state_t;

    state_t                 r_state,     w_state_nxt;
    logic [KEY_WIDTH-1:0]   r_shadow,    w_shadow_nxt;
    logic [c_CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [TAG_W-1:0]       r_tag,       w_tag_nxt;
    logic                   r_frame_ok,  w_frame_ok_nxt;
    logic [KEY_WIDTH-1:0]   r_key,       w_key_nxt;
    logic                   r_key_valid, w_key_valid_nxt;
    logic [c_FAIL_W-1:0]    r_fail,      w_fail_nxt;
    logic                   r_locked,    w_locked_nxt;
    logic                   r_ready,     w_ready_nxt;

    logic                   w_beat;
    logic                   w_final;
    logic [TAG_W-1:0]       w_fold;
    logic [c_FAIL_W-1:0]    w_fail_inc;

    assign w_beat     = load_valid && r_ready;
    assign w_final    = (r_cnt == c_CNT_W'(c_BEATS - 1));
    assign w_fail_inc = r_fail + 1'b1;

    always_comb begin
        w_fold = '0;
        for (int i = 0; i < c_SLICES; i++) begin
            w_fold = w_fold ^ r_shadow[i*TAG_W +: TAG_W];
        end
    end

    // The counter is zero on every entry to IDLE, so IDLE and LOAD share the beat path.
    always_comb begin
        w_state_nxt     = r_state;
        w_shadow_nxt    = r_shadow;
        w_cnt_nxt       = r_cnt;
        w_tag_nxt       = r_tag;
        w_frame_ok_nxt  = r_frame_ok;
        w_key_nxt       = r_key;
        w_key_valid_nxt = r_key_valid;
        w_fail_nxt      = r_fail;
        w_locked_nxt    = r_locked;
        case (r_state)
            S_IDLE, S_LOAD: begin
                if (key_clear) begin
                    w_key_nxt       = DECOY;
                    w_key_valid_nxt = 1'b0;
                    w_cnt_nxt       = '0;
                    w_state_nxt     = S_IDLE;
                end else if (w_beat) begin
                    w_shadow_nxt[r_cnt*CHUNK_W +: CHUNK_W] = load_data;
                    if (load_last || w_final) begin
                        w_state_nxt    = S_CHECK;
                        w_cnt_nxt      = '0;
                        w_tag_nxt      = tag_in;
                        w_frame_ok_nxt = load_last && w_final;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            S_CHECK: begin
                w_state_nxt = S_IDLE;
                if (key_clear) begin
                    w_key_nxt       = DECOY;
                    w_key_valid_nxt = 1'b0;
                end else if (r_frame_ok && (w_fold == r_tag)) begin
                    w_key_nxt       = r_shadow;
                    w_key_valid_nxt = 1'b1;
                end else begin
                    w_fail_nxt = w_fail_inc;
                    if (w_fail_inc == c_FAIL_W'(MAX_FAILS)) begin
                        w_key_nxt       = DECOY;
                        w_key_valid_nxt = 1'b0;
                        w_locked_nxt    = 1'b1;
                        w_state_nxt     = S_LOCKED;
                    end
                end
            end
            S_LOCKED: begin
                w_state_nxt = S_LOCKED;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_ready_nxt = (w_state_nxt == S_IDLE) || (w_state_nxt == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_shadow    <= '0;
            r_cnt       <= '0;
            r_tag       <= '0;
            r_frame_ok  <= 1'b0;
            r_key       <= DECOY;
            r_key_valid <= 1'b0;
            r_fail      <= '0;
            r_locked    <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_shadow    <= w_shadow_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tag       <= w_tag_nxt;
            r_frame_ok  <= w_frame_ok_nxt;
            r_key       <= w_key_nxt;
            r_key_valid <= w_key_valid_nxt;
            r_fail      <= w_fail_nxt;
            r_locked    <= w_locked_nxt;
            r_ready     <= w_ready_nxt;
        end
    end

    assign load_ready = r_ready;
    assign key_out    = r_key;
    assign key_valid  = r_key_valid;
    assign fail_cnt   = r_fail;
    assign locked_out = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_rll_key_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rll_key_loader
//  Purpose  : Self-checking bench for rll_key_loader against a queue-based
//             reference model of the key-loading protocol.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rll_key_loader;

    localparam logic [31:0] c_DECOY = 32'hA5A5A5A5;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_data;
    logic        load_last;
    logic [7:0]  tag_in;
    logic        key_clear;
    logic [31:0] key_out;
    logic        key_valid;
    logic [1:0]  fail_cnt;
    logic        locked_out;

    int n_checks = 0;
    int n_errors = 0;

    rll_key_loader #(
        .KEY_WIDTH (32),
        .CHUNK_W   (8),
        .TAG_W     (8),
        .MAX_FAILS (3),
        .DECOY     (c_DECOY)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_last  (load_last),
        .tag_in     (tag_in),
        .key_clear  (key_clear),
        .key_out    (key_out),
        .key_valid  (key_valid),
        .fail_cnt   (fail_cnt),
        .locked_out (locked_out)
    );

    always #5 clk = ~clk;

    // Reference model: received beats kept as a byte queue.
    logic [7:0]  m_q[$];
    logic [31:0] m_key;
    logic        m_valid;
    int          m_fail;
    logic        m_locked;
    logic        m_checking;
    logic        m_frame_ok;
    logic [7:0]  m_tag;

    function automatic logic m_ready();
        return !m_locked && !m_checking;
    endfunction

    function automatic logic [7:0] q_fold();
        logic [7:0] f = 8'h00;
        foreach (m_q[i]) f = f ^ m_q[i];
        return f;
    endfunction

    function automatic logic [31:0] q_key();
        logic [31:0] k = 32'h0;
        foreach (m_q[i]) k = k | (32'(m_q[i]) << (8 * i));
        return k;
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_q.delete();
            m_key = c_DECOY; m_valid = 1'b0; m_fail = 0;
            m_locked = 1'b0; m_checking = 1'b0;
        end else if (m_locked) begin
        end else if (m_checking) begin
            m_checking = 1'b0;
            if (key_clear) begin
                m_key = c_DECOY; m_valid = 1'b0;
            end else if (m_frame_ok && q_fold() == m_tag) begin
                m_key = q_key(); m_valid = 1'b1;
            end else begin
                m_fail++;
                if (m_fail == 3) begin
                    m_locked = 1'b1; m_key = c_DECOY; m_valid = 1'b0;
                end
            end
            m_q.delete();
        end else if (key_clear) begin
            m_key = c_DECOY; m_valid = 1'b0;
            m_q.delete();
        end else if (load_valid) begin
            m_q.push_back(load_data);
            if (load_last || m_q.size() == 4) begin
                m_checking = 1'b1;
                m_frame_ok = load_last && (m_q.size() == 4);
                m_tag      = tag_in;
            end
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_val("key_out",    key_out,           m_key);
        check_val("key_valid",  32'(key_valid),    32'(m_valid));
        check_val("fail_cnt",   32'(fail_cnt),     32'(m_fail));
        check_val("locked_out", 32'(locked_out),   32'(m_locked));
        check_val("load_ready", 32'(load_ready),   32'(m_ready()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] key_fold(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    // Sends nbeats beats of key, raising load_last on beat last_at (-1: never).
    task automatic send_key(input logic [31:0] key, input int nbeats, input int last_at,
                            input logic [7:0] tag, input int gap_pct);
        for (int b = 0; b < nbeats; b++) begin
            int waited = 0;
            while ($urandom_range(99) < 32'(gap_pct)) begin
                load_valid = 1'b0;
                tick();
            end
            load_valid = 1'b1;
            load_data  = key[8*b +: 8];
            load_last  = (b == last_at);
            tag_in     = tag;
            while (!m_ready() && waited < 50) begin
                tick();
                waited++;
            end
            if (waited >= 50) check_val("beat_timeout", 32'(waited), 32'd0);
            tick();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        load_data  = $urandom();
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0;
        tag_in = 8'h00; key_clear = 1'b0;
        m_key = c_DECOY; m_valid = 1'b0; m_fail = 0; m_locked = 1'b0;
        m_checking = 1'b0; m_frame_ok = 1'b0; m_tag = 8'h00;

        do_reset();
        check_val("rst_key", key_out, c_DECOY);
        check_val("rst_ready", 32'(load_ready), 32'd1);

        // Bad tag from a clean start
        send_key(32'h12345678, 4, 3, 8'h09, 0);
        tick();
        check_val("badtag_fail", 32'(fail_cnt), 32'd1);
        check_val("badtag_key", key_out, c_DECOY);

        // Good load: not visible one edge after the handshake, visible after two
        do_reset();
        send_key(32'h12345678, 4, 3, 8'h08, 0);
        check_val("good_early", 32'(key_valid), 32'd0);
        tick();
        check_val("good_key", key_out, 32'h12345678);
        check_val("good_valid", 32'(key_valid), 32'd1);

        // Framing errors keep the committed key
        send_key(32'h12345678, 3, 2, 8'h08, 0);
        tick();
        check_val("early_last", 32'(fail_cnt), 32'd1);
        send_key(32'h12345678, 4, -1, 8'h08, 0);
        tick();
        check_val("no_last", 32'(fail_cnt), 32'd2);
        check_val("frame_key", key_out, 32'h12345678);

        // Lockout
        send_key(32'hDEADBEEF, 4, 3, 8'h00, 0);
        tick();
        check_val("lock", 32'(locked_out), 32'd1);
        check_val("lock_key", key_out, c_DECOY);
        load_valid = 1'b1; load_last = 1'b1; tag_in = key_fold(32'h000000AA); load_data = 8'hAA;
        for (int i = 0; i < 6; i++) begin
            key_clear = i[0];
            tick();
        end
        key_clear = 1'b0; load_valid = 1'b0; load_last = 1'b0;
        check_val("lock_hold", 32'(locked_out), 32'd1);
        do_reset();
        check_val("unlock", 32'(locked_out), 32'd0);
        check_val("unlock_fail", 32'(fail_cnt), 32'd0);

        // Clear coincident with beat 2, then a stalled reload, then clear in CHECK
        send_key(32'h0BADF00D, 4, 3, key_fold(32'h0BADF00D), 0);
        tick();
        send_key(32'h11223344, 2, -1, 8'h00, 0);
        load_valid = 1'b1; load_data = 8'h22; key_clear = 1'b1;
        tick();
        load_valid = 1'b0; key_clear = 1'b0;
        check_val("clr_valid", 32'(key_valid), 32'd0);
        send_key(32'h11223344, 4, 3, key_fold(32'h11223344), 40);
        tick();
        check_val("stall_key", key_out, 32'h11223344);
        send_key(32'h55667788, 4, 3, key_fold(32'h55667788), 0);
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        check_val("chk_clr", 32'(key_valid), 32'd0);
        check_val("chk_clr_fail", 32'(fail_cnt), 32'd0);

        // Reset in the middle of a load
        send_key(32'h99999999, 2, -1, 8'h00, 0);
        do_reset();
        send_key(32'hCAFEBABE, 4, 3, key_fold(32'hCAFEBABE), 0);
        tick();
        check_val("midrst_key", key_out, 32'hCAFEBABE);

        // Randomised traffic
        for (int n = 0; n < 60; n++) begin
            logic [31:0] k;
            logic [7:0]  t;
            int          sel;
            int          nb;
            int          la;
            if (m_locked || $urandom_range(19) == 0) do_reset();
            k   = $urandom();
            t   = key_fold(k);
            if ($urandom_range(99) < 25) t = t ^ 8'($urandom_range(255, 1));
            sel = $urandom_range(9);
            if (sel < 7)       begin nb = 4; la = 3;  end
            else if (sel < 9)  begin la = $urandom_range(2); nb = la + 1; end
            else               begin nb = 4; la = -1; end
            send_key(k, nb, la, t, $urandom_range(50));
            key_clear = ($urandom_range(9) == 0);
            tick();
            key_clear = 1'b0;
            for (int w = 0; w < $urandom_range(2); w++) tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
